// File: rtl/fs_pkg.sv
// Shared constants for the registered ripple-borrow subtractor.
package fs_pkg;

    localparam int FS_DEFAULT_WIDTH = 1;

    // Per-bit reset value of the difference register, replicated to WIDTH at use.
    localparam logic FS_DIFF_RST_BIT = 1'b0;

endpackage

// File: rtl/half_subtractor.sv
// Single-bit half subtractor: d = x - y, bo is the borrow out.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/full_subtractor_hs.sv
// Registered ripple-borrow subtractor, diff = a - b - bin, one cycle latency.
// Optional zero flag output enabled by FS_ZERO_FLAG_EN.
module full_subtractor_hs
    import fs_pkg::*;
#(
    parameter int WIDTH = FS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef FS_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    // Handshake: operands are taken on every rising edge where in_valid=1;
    // there is no ready, so a new operand set may arrive every cycle.
    // out_valid pulses for exactly the cycle after acceptance, and diff/bout
    // keep their last value while out_valid=0.

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] diff_next;

    assign borrow[0] = bin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        half_subtractor u_hs1 (
            .x  (a[gi]),
            .y  (b[gi]),
            .d  (d1[gi]),
            .bo (b1[gi])
        );

        half_subtractor u_hs2 (
            .x  (d1[gi]),
            .y  (borrow[gi]),
            .d  (diff_next[gi]),
            .bo (b2[gi])
        );

        assign borrow[gi+1] = b1[gi] | b2[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Result registers only load on accepted operands, so idle cycles do not toggle them.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff <= {WIDTH{FS_DIFF_RST_BIT}};
            bout <= 1'b0;
        end else if (in_valid) begin
            diff <= diff_next;
            bout <= borrow[WIDTH];
        end
    end

`ifdef FS_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
        end else if (in_valid) begin
            zero <= (diff_next == '0);
        end
    end
`endif

endmodule

// File: tb/tb_full_subtractor_hs.sv
// Self-checking bench for full_subtractor_hs at WIDTH 1, 4 and 8.
module tb_full_subtractor_hs;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       v1, a1, b1, bin1, ov1, df1, bo1;
    logic       v4, bin4, ov4, bo4;
    logic [3:0] a4, b4, df4;
    logic       v8, bin8, ov8, bo8;
    logic [7:0] a8, b8, df8;
`ifdef FS_ZERO_FLAG_EN
    logic       z1, z4, z8;
`endif

    full_subtractor_hs #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .bin(bin1),
        .out_valid(ov1), .diff(df1), .bout(bo1)
`ifdef FS_ZERO_FLAG_EN
        , .zero(z1)
`endif
    );

    full_subtractor_hs #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .bin(bin4),
        .out_valid(ov4), .diff(df4), .bout(bo4)
`ifdef FS_ZERO_FLAG_EN
        , .zero(z4)
`endif
    );

    full_subtractor_hs #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .diff(df8), .bout(bo8)
`ifdef FS_ZERO_FLAG_EN
        , .zero(z8)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: plain integer arithmetic, packed as {bout, diff}.
    function automatic logic [31:0] ref_sub(input int a, input int b, input int bin, input int w);
        int t;
        int d;
        logic bo;
        t  = a - b - bin;
        d  = (t + (1 << w)) % (1 << w);
        bo = (a < b + bin);
        return (32'(bo) << w) | 32'(d);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
    endtask

    task automatic send1(input int a, input int b, input int bin);
        logic [31:0] e;
        v1 = 1'b1; a1 = a[0]; b1 = b[0]; bin1 = bin[0];
        e = ref_sub(a, b, bin, 1);
        step();
        v1 = 1'b0;
        check("w1_valid", 32'(ov1), 32'd1);
        check("w1_result", {30'd0, bo1, df1}, e);
    endtask

    task automatic send4(input int a, input int b, input int bin);
        logic [31:0] e;
        v4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; bin4 = bin[0];
        e = ref_sub(a, b, bin, 4);
        step();
        v4 = 1'b0;
        check("w4_valid", 32'(ov4), 32'd1);
        check("w4_result", {27'd0, bo4, df4}, e);
`ifdef FS_ZERO_FLAG_EN
        check("w4_zero", 32'(z4), 32'(e[3:0] == 4'd0));
`endif
    endtask

    task automatic send8(input int a, input int b, input int bin);
        logic [31:0] e;
        v8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; bin8 = bin[0];
        e = ref_sub(a, b, bin, 8);
        step();
        v8 = 1'b0;
        check("w8_valid", 32'(ov8), 32'd1);
        check("w8_result", {23'd0, bo8, df8}, e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [8:0] last8;
        logic [8:0] e8;
        int ra, rb, rbin;

        rst = 1'b1;
        idle_all();
        a1 = 0; b1 = 0; bin1 = 0;
        a4 = 0; b4 = 0; bin4 = 0;
        a8 = 0; b8 = 0; bin8 = 0;
        step();
        step();
        check("rst_w1", {29'd0, ov1, bo1, df1}, 32'd0);
        check("rst_w4", {26'd0, ov4, bo4, df4}, 32'd0);
        check("rst_w8", {22'd0, ov8, bo8, df8}, 32'd0);
`ifdef FS_ZERO_FLAG_EN
        check("rst_zero", {29'd0, z1, z4, z8}, 32'd0);
`endif
        rst = 1'b0;

        // WIDTH=1 exhaustive truth table, back to back.
        for (int k = 0; k < 8; k++) send1((k >> 2) & 1, (k >> 1) & 1, k & 1);

        // Reset wins over in_valid; result appears one cycle after release.
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_hold_w1", {29'd0, ov1, bo1, df1}, 32'd0);
        end
        rst = 1'b0;
        step();
        check("rst_release_valid", 32'(ov1), 32'd1);
        check("rst_release_result", {30'd0, bo1, df1}, 32'b01);
        v1 = 1'b0;

        // Idle hold: outputs keep the last result while operands wander.
        send1(1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            a1 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            bin1 = 1'($urandom_range(0, 1));
            step();
            check("idle_w1_valid", 32'(ov1), 32'd0);
            check("idle_w1_hold", {30'd0, bo1, df1}, 32'b11);
        end

        // WIDTH=4 zero flag and boundaries.
        send4(5, 4, 1);
        send4(0, 0, 1);
        send4(9, 9, 0);
        send4(15, 0, 0);

        // WIDTH=8 wrap and boundary cases.
        send8(8'h00, 8'h00, 1);
        send8(8'h80, 8'h01, 0);
        send8(8'h5a, 8'h5a, 0);
        send8(8'hff, 8'h00, 0);
        last8 = 9'(ref_sub(8'hff, 8'h00, 0, 8));

        // WIDTH=8 random stream, ~70% valid, checked one cycle later.
        for (int i = 0; i < 1000; i++) begin
            ra   = int'($urandom_range(0, 255));
            rb   = int'($urandom_range(0, 255));
            rbin = int'($urandom_range(0, 1));
            v8   = ($urandom_range(0, 99) < 70);
            a8 = ra[7:0]; b8 = rb[7:0]; bin8 = rbin[0];
            if (v8) exp_q.push_back(9'(ref_sub(ra, rb, rbin, 8)));
            step();
            if (v8) begin
                e8 = exp_q.pop_front();
                last8 = e8;
                check("stream_valid", 32'(ov8), 32'd1);
            end else begin
                check("stream_idle_valid", 32'(ov8), 32'd0);
            end
            check("stream_result", {23'd0, bo8, df8}, {23'd0, last8});
`ifdef FS_ZERO_FLAG_EN
            check("stream_zero", 32'(z8), 32'(last8[7:0] == 8'd0));
`endif
        end
        v8 = 1'b0;
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream drops the in-flight operand.
        v8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        v8 = 1'b0;
        check("midrst_w8", {22'd0, ov8, bo8, df8}, 32'd0);
        step();
        check("midrst_w8_idle", {22'd0, ov8, bo8, df8}, 32'd0);
        send8(8'h10, 8'h01, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/full_subtractor_hs.md
Name: full_subtractor_hs

Overview:
- Registered ripple-borrow subtractor built from half-subtractor cells (two half subtractors plus an OR per bit).
- Computes diff = a - b - bin and the borrow-out, with a valid qualifier and one cycle of latency.
- Used as the arithmetic leaf in datapath blocks. With WIDTH=1 it is the classic single-bit full subtractor, registered.

Parameters:
- WIDTH, 1, operand and difference width in bits (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout valid.
- diff  output  WIDTH  registered difference.
- bout  output  1  registered borrow-out.
- zero  output  1  present only with FS_ZERO_FLAG_EN.

Interface decision: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Per bit i, with borrow chain c[0]=bin:
  - half subtractor 1: d1 = a[i]^b[i], b1 = ~a[i]&b[i].
  - half subtractor 2: diff[i] = d1^c[i], b2 = ~d1&c[i].
  - c[i+1] = b1|b2; bout = c[WIDTH].
- Arithmetic equivalent: diff = (a - b - bin) mod 2^WIDTH; bout = 1 iff a < b + bin, unsigned.
- Latency is exactly 1 cycle. Result of operands sampled at edge N is visible after edge N, alongside out_valid=1.
- in_valid=1 at an edge: register diff and bout, set out_valid=1.
- in_valid=0 at an edge: out_valid=0; diff and bout hold their previous values (no toggling on idle cycles).
- No backpressure; a new operand can be accepted every cycle.
- Reset (rst=1 at an edge): out_valid=0, diff=0, bout=0 (and zero=0). Reset takes priority over in_valid.
- Reset mid-stream drops the in-flight result. The first valid output after reset comes one cycle after the first in_valid following rst deassertion.
- X-free: all outputs are defined from the first clock edge with rst=1.
- Boundary cases:
  - a=b, bin=0 gives diff=0, bout=0.
  - a=0, b=0, bin=1 gives diff=all-ones, bout=1.
  - a=all-ones, b=0, bin=0 gives diff=all-ones, bout=0.

Optional Feature:
- Macro: FS_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit), registered with the same timing and hold rules as diff.
  - zero=1 iff the next diff is all-zero, regardless of bout.
  - Reset value 0.
- Undefined: port zero does not exist; the remaining behaviour is identical.

Decomposition:
- Shared package fs_pkg holds:
  - localparam FS_DEFAULT_WIDTH = 1.
  - A reset-value constant for diff (all zeros).
  - No typedefs required.
- One natural sub-module: half_subtractor (inputs x, y; outputs d = x^y, bo = ~x&y). It is instantiated twice per bit via a generate loop.
- Borrow OR and output registers live in full_subtractor_hs.

Test Plan:
- WIDTH=1 exhaustive truth table: drive {a,b,bin} = 0..7, one per cycle with in_valid=1. Required (diff,bout) one cycle later: 000->(0,0), 001->(1,1), 010->(1,1), 011->(0,1), 100->(1,0), 101->(0,0), 110->(0,0), 111->(1,1).
- Reset:
  - Hold rst=1 with in_valid=1, a=1, b=0 -> out_valid=0, diff=0, bout=0 every cycle.
  - Release rst -> result (1,0) appears one cycle later.
- Idle hold: send a=1, b=1, bin=1 (result diff=1, bout=1), then in_valid=0 for 3 cycles -> out_valid=0 and diff/bout stay at 1,1.
- WIDTH=8 wrap: a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0.
- WIDTH=8 back-to-back random stream: 1000 cycles with in_valid at 70% -> each result matches (a-b-bin) mod 256 and the borrow reference one cycle later, with no dropped results.
- FS_ZERO_FLAG_EN, WIDTH=4:
  - a=5, b=4, bin=1 -> diff=0, bout=0, zero=1.
  - a=0, b=0, bin=1 -> zero=0.
